// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle fetch/decode/execute control FSM for the 8-bit accumulator computer
module cpu_control_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] instr,
    input  logic       z_flag,
    input  logic       c_flag,
    input  logic       mem_ack,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       ir_en,
    output logic       acc_en,
    output logic       flags_en,
    output logic [2:0] alu_op,
    output logic       src_imm,
    output logic       addr_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       halted,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_NOT = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_NOT   = 3'b101;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [3:0] opcode;
    logic       in_access;
    logic       timeout;

    assign opcode    = instr[7:4];
    assign in_access = (state == S_FETCH) || (state == S_MEM);
    // A same-cycle ack always beats the timeout.
    assign timeout   = in_access && !mem_ack && (wait_cnt == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            error    <= 1'b0;
        end else begin
            state <= state_next;
            if (in_access && !mem_ack && !timeout) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
            if (timeout) begin
                error <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack)      state_next = S_DECODE;
                else if (timeout) state_next = S_HALT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR:
                        state_next = S_MEM;
                    OP_LDI, OP_JMP, OP_JZ, OP_JC, OP_NOT:
                        state_next = S_EXEC;
                    OP_HLT:
                        state_next = S_HALT;
                    default:
                        state_next = S_FETCH;
                endcase
            end
            S_EXEC: state_next = S_FETCH;
            S_MEM: begin
                if (mem_ack)      state_next = S_FETCH;
                else if (timeout) state_next = S_HALT;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        ir_en    = 1'b0;
        acc_en   = 1'b0;
        flags_en = 1'b0;
        alu_op   = ALU_PASSB;
        src_imm  = 1'b0;
        addr_sel = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        halted   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd = 1'b1;
                ir_en  = mem_ack;
                pc_inc = mem_ack;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LDI: begin
                        acc_en  = 1'b1;
                        src_imm = 1'b1;
                    end
                    OP_NOT: begin
                        acc_en   = 1'b1;
                        flags_en = 1'b1;
                        alu_op   = ALU_NOT;
                    end
                    OP_JMP:  pc_load = 1'b1;
                    OP_JZ:   pc_load = z_flag;
                    OP_JC:   pc_load = c_flag;
                    default: pc_load = 1'b0;
                endcase
            end
            S_MEM: begin
                addr_sel = 1'b1;
                mem_wr   = (opcode == OP_STA);
                mem_rd   = (opcode != OP_STA);
                case (opcode)
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_AND:  alu_op = ALU_AND;
                    OP_OR:   alu_op = ALU_OR;
                    default: alu_op = ALU_PASSB;
                endcase
                // Register enables only fire on the cycle the memory completes.
                if (mem_ack && opcode != OP_STA) begin
                    acc_en   = 1'b1;
                    flags_en = (opcode != OP_LDA);
                end
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - directed self-checking bench for cpu_control_unit
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] instr;
    logic       z_flag;
    logic       c_flag;
    logic       mem_ack;
    logic       pc_inc, pc_load, ir_en, acc_en, flags_en;
    logic [2:0] alu_op;
    logic       src_imm, addr_sel, mem_rd, mem_wr, halted, error;

    int checks   = 0;
    int failures = 0;

    cpu_control_unit #(.TIMEOUT(15)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .instr    (instr),
        .z_flag   (z_flag),
        .c_flag   (c_flag),
        .mem_ack  (mem_ack),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .ir_en    (ir_en),
        .acc_en   (acc_en),
        .flags_en (flags_en),
        .alu_op   (alu_op),
        .src_imm  (src_imm),
        .addr_sel (addr_sel),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .halted   (halted),
        .error    (error)
    );

    always #5 clk = ~clk;

    logic [13:0] outs;
    assign outs = {pc_inc, pc_load, ir_en, acc_en, flags_en, alu_op,
                   src_imm, addr_sel, mem_rd, mem_wr, halted, error};

    // Expected output vector, fields in the same order as outs.
    function automatic logic [13:0] ev(input logic pi, input logic pl, input logic ir,
                                       input logic acc, input logic fl, input logic [2:0] alu,
                                       input logic si, input logic as, input logic rd,
                                       input logic wr, input logic h, input logic e);
        return {pi, pl, ir, acc, fl, alu, si, as, rd, wr, h, e};
    endfunction

    localparam logic [13:0] FETCH_WAIT = 14'b00000_000_0010_00;
    localparam logic [13:0] ALL_ZERO   = 14'd0;

    task automatic restart();
        reset = 1'b0;
        start = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; instr = 8'h00; z_flag = 1'b0; c_flag = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (outs !== ALL_ZERO) begin
            failures++; $display("FAIL reset_outs got=%b exp=%b", outs, ALL_ZERO);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== ALL_ZERO) begin
            failures++; $display("FAIL idle_release got=%b exp=%b", outs, ALL_ZERO);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (outs !== FETCH_WAIT) begin
            failures++; $display("FAIL fetch_entry got=%b exp=%b", outs, FETCH_WAIT);
        end
    endtask

    task automatic test_ldi();
        logic [13:0] exp;
        instr = 8'h75;
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (outs !== FETCH_WAIT) begin
                failures++; $display("FAIL ldi_fetch_wait got=%b exp=%b", outs, FETCH_WAIT);
            end
        end
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        exp = ev(1, 0, 1, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0);
        checks++;
        if (outs !== exp) begin
            failures++; $display("FAIL ldi_fetch_ack got=%b exp=%b", outs, exp);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if (outs !== ALL_ZERO) begin
            failures++; $display("FAIL ldi_decode got=%b exp=%b", outs, ALL_ZERO);
        end
        @(negedge clk);
        #1;
        exp = ev(0, 0, 0, 1, 0, 3'b000, 1, 0, 0, 0, 0, 0);
        checks++;
        if (outs !== exp) begin
            failures++; $display("FAIL ldi_exec got=%b exp=%b", outs, exp);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== FETCH_WAIT) begin
            failures++; $display("FAIL ldi_refetch got=%b exp=%b", outs, FETCH_WAIT);
        end
    endtask

    task automatic test_mem_ops();
        logic [7:0]  ops  [4] = '{8'h3A, 8'h15, 8'h42, 8'h61};
        logic [13:0] exps [4];
        logic [13:0] exp;
        exps[0] = ev(0, 0, 0, 1, 1, 3'b001, 0, 1, 1, 0, 0, 0);
        exps[1] = ev(0, 0, 0, 1, 0, 3'b000, 0, 1, 1, 0, 0, 0);
        exps[2] = ev(0, 0, 0, 1, 1, 3'b010, 0, 1, 1, 0, 0, 0);
        exps[3] = ev(0, 0, 0, 1, 1, 3'b100, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            instr = ops[i]; mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            @(negedge clk);
            mem_ack = 1'b1;
            #1;
            checks++;
            if (outs !== exps[i]) begin
                failures++; $display("FAIL mem_ack_op%0h got=%b exp=%b", ops[i], outs, exps[i]);
            end
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            checks++;
            if (outs !== FETCH_WAIT) begin
                failures++; $display("FAIL mem_refetch_op%0h got=%b exp=%b", ops[i], outs, FETCH_WAIT);
            end
        end
        @(negedge clk);
        instr = 8'h2A; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        #1;
        exp = ev(0, 0, 0, 0, 0, 3'b000, 0, 1, 0, 1, 0, 0);
        checks++;
        if (outs !== exp) begin
            failures++; $display("FAIL sta_wait got=%b exp=%b", outs, exp);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        checks++;
        if (outs !== exp) begin
            failures++; $display("FAIL sta_ack got=%b exp=%b", outs, exp);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if (outs !== FETCH_WAIT) begin
            failures++; $display("FAIL sta_refetch got=%b exp=%b", outs, FETCH_WAIT);
        end
    endtask

    task automatic test_exec_ops();
        logic [7:0]  ops [6] = '{8'h94, 8'h94, 8'h84, 8'hA0, 8'hA0, 8'hB3};
        logic        zs  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        cs  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [13:0] exps[6];
        exps[0] = ALL_ZERO;
        exps[1] = ev(0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        exps[2] = ev(0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        exps[3] = ALL_ZERO;
        exps[4] = ev(0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        exps[5] = ev(0, 0, 0, 1, 1, 3'b101, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            instr = ops[i]; mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            @(negedge clk);
            z_flag = zs[i]; c_flag = cs[i];
            #1;
            checks++;
            if (outs !== exps[i]) begin
                failures++; $display("FAIL exec_%0d_op%0h got=%b exp=%b", i, ops[i], outs, exps[i]);
            end
            @(negedge clk);
            #1;
            checks++;
            if (outs !== FETCH_WAIT) begin
                failures++; $display("FAIL exec_refetch_%0d got=%b exp=%b", i, outs, FETCH_WAIT);
            end
        end
    endtask

    task automatic test_nop_codes();
        logic [7:0] ops [4] = '{8'h00, 8'hC1, 8'hD2, 8'hE3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            instr = ops[i]; mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            @(negedge clk);
            #1;
            checks++;
            if (outs !== FETCH_WAIT) begin
                failures++; $display("FAIL nop_op%0h got=%b exp=%b", ops[i], outs, FETCH_WAIT);
            end
        end
    endtask

    task automatic test_timeout_boundary();
        logic [13:0] exp;
        instr = 8'h00;
        repeat (14) @(negedge clk);
        #1;
        checks++;
        if (outs !== FETCH_WAIT) begin
            failures++; $display("FAIL tob_wait14 got=%b exp=%b", outs, FETCH_WAIT);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        exp = ev(1, 0, 1, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0);
        checks++;
        if (outs !== exp) begin
            failures++; $display("FAIL tob_ack_at_limit got=%b exp=%b", outs, exp);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if (outs !== ALL_ZERO) begin
            failures++; $display("FAIL tob_decode got=%b exp=%b", outs, ALL_ZERO);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== FETCH_WAIT) begin
            failures++; $display("FAIL tob_refetch got=%b exp=%b", outs, FETCH_WAIT);
        end
    endtask

    task automatic test_timeout();
        logic [13:0] exp;
        repeat (15) @(negedge clk);
        #1;
        checks++;
        if (outs !== FETCH_WAIT) begin
            failures++; $display("FAIL to_last_wait got=%b exp=%b", outs, FETCH_WAIT);
        end
        @(negedge clk);
        #1;
        exp = ev(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1);
        checks++;
        if (outs !== exp) begin
            failures++; $display("FAIL to_halt got=%b exp=%b", outs, exp);
        end
        repeat (3) begin
            @(negedge clk);
            start = 1'b1; mem_ack = 1'b1;
            @(negedge clk);
            start = 1'b0; mem_ack = 1'b0;
        end
        #1;
        checks++;
        if (outs !== exp) begin
            failures++; $display("FAIL to_start_ignored got=%b exp=%b", outs, exp);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== ALL_ZERO) begin
            failures++; $display("FAIL to_reset_clears got=%b exp=%b", outs, ALL_ZERO);
        end
    endtask

    task automatic test_hlt();
        logic [13:0] exp;
        restart();
        @(negedge clk);
        instr = 8'hF0; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        #1;
        exp = ev(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
        checks++;
        if (outs !== exp) begin
            failures++; $display("FAIL hlt_state got=%b exp=%b", outs, exp);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [13:0] exp;
        restart();
        @(negedge clk);
        instr = 8'h15; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        #1;
        exp = ev(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 0, 0, 0);
        checks++;
        if (outs !== exp) begin
            failures++; $display("FAIL rmm_mem_wait got=%b exp=%b", outs, exp);
        end
        mem_ack = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== ALL_ZERO) begin
            failures++; $display("FAIL rmm_async_drop got=%b exp=%b", outs, ALL_ZERO);
        end
        @(negedge clk);
        reset = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (outs !== ALL_ZERO) begin
            failures++; $display("FAIL rmm_idle got=%b exp=%b", outs, ALL_ZERO);
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_mem_ops();
        test_exec_ops();
        test_nop_codes();
        test_timeout_boundary();
        test_timeout();
        test_hlt();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
